// File: rtl/button_repeat_pkg.sv
// Shared definitions for the push-button conditioner.
//   - rep_state_t : auto-repeat FSM encoding (2'd3 is unused and decodes to IDLE)
//   - DEF_*       : default timing constants for board use
//   - released_level : idle (not pressed) pin level for a given button polarity
package button_repeat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_DB_TICKS    = 16;
    localparam int DEF_DELAY_TICKS = 500;
    localparam int DEF_RATE_TICKS  = 100;

    // Pin level seen when the button is not pressed.
    function automatic logic released_level(input logic active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/button_repeat_sync.sv
// Two-flop synchroniser for an asynchronous panel input. Both flops reset
// to RST_VAL so a reset never produces a spurious edge downstream. Also
// used for the other panel inputs (CLKSEL, S1, S2).
// Ports:
//   clk - sampling clock (posedge)
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronised output
module pb_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/button_repeat.sv
// Front-end conditioner for one front-panel push-button: synchronises the
// raw pin, debounces it on TICK_EN, emits press/release pulses and a STEP
// pulse on press plus auto-repeat STEPs while held.
// Ports:
//   CLK       - system clock, all flops on posedge
//   RST       - synchronous active-high reset
//   TICK_EN   - one-CLK strobe pacing debounce/repeat timing
//   PB        - raw asynchronous button pin
//   PB_STATE  - debounced level, 1 = pressed
//   PB_DOWN   - one-cycle pulse on accepted press
//   PB_UP     - one-cycle pulse on accepted release
//   STEP      - one-cycle pulse on press and on each auto-repeat
//   REPEATING - high while in the REPEAT state
module button_repeat
    import button_repeat_pkg::*;
#(
    parameter logic ACTIVE_LOW  = 1'b1,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter int   DB_TICKS    = DEF_DB_TICKS,
    parameter int   DELAY_TICKS = DEF_DELAY_TICKS,
    parameter int   RATE_TICKS  = DEF_RATE_TICKS
) (
    input  logic CLK,
    input  logic RST,
    input  logic TICK_EN,
    input  logic PB,
    output logic PB_STATE,
    output logic PB_DOWN,
    output logic PB_UP,
    output logic STEP,
    output logic REPEATING
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);

    // Limits must be reachable by a counter that is compared, never wrapped.
    if (DB_TICKS < 1 || longint'(DB_TICKS) > CNT_MAX ||
        DELAY_TICKS < 1 || longint'(DELAY_TICKS) > CNT_MAX ||
        RATE_TICKS < 1 || longint'(RATE_TICKS) > CNT_MAX) begin : g_bad_limits
        $error("button_repeat: timing limit out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DB_LIM    = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(RATE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync2_s;
    logic             pressed_s;
    logic             accept_s;
    logic             accept_press_s;
    logic             accept_release_s;
    logic [CNT_W-1:0] dcnt_r;
    logic [CNT_W-1:0] rcnt_r;
    rep_state_t       state_r;

    pb_sync #(
        .RST_VAL (released_level(ACTIVE_LOW))
    ) u_pb_sync (
        .clk (CLK),
        .rst (RST),
        .d   (PB),
        .q   (sync2_s)
    );

    assign pressed_s = ACTIVE_LOW ? ~sync2_s : sync2_s;

    // Debounce accept: stable differing level for DB_TICKS ticks.
    always_comb begin
        accept_s = 1'b0;
        if (TICK_EN && (dcnt_r == DB_LIM) && (pressed_s != PB_STATE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign accept_press_s   = accept_s & pressed_s;
    assign accept_release_s = accept_s & ~pressed_s;

    // Debounced level, edge pulses and stability counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PB_STATE <= 1'b0;
            PB_DOWN  <= 1'b0;
            PB_UP    <= 1'b0;
            dcnt_r   <= '0;
        end else begin
            PB_DOWN <= accept_press_s;
            PB_UP   <= accept_release_s;
            if (pressed_s == PB_STATE) begin
                dcnt_r <= '0;
            end else if (accept_s) begin
                PB_STATE <= ~PB_STATE;
                dcnt_r   <= '0;
            end else if (TICK_EN) begin
                dcnt_r <= dcnt_r + CNT_ONE;
            end else begin
                dcnt_r <= dcnt_r;
            end
        end
    end

    // Auto-repeat FSM; an accepted release overrides any coinciding expiry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            rcnt_r    <= '0;
            STEP      <= 1'b0;
            REPEATING <= 1'b0;
        end else begin
            STEP <= 1'b0;
            if (accept_release_s) begin
                state_r   <= ST_IDLE;
                rcnt_r    <= '0;
                REPEATING <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        REPEATING <= 1'b0;
                        if (accept_press_s) begin
                            STEP    <= 1'b1;
                            state_r <= ST_DELAY;
                            rcnt_r  <= '0;
                        end else begin
                            rcnt_r <= '0;
                        end
                    end
                    ST_DELAY: begin
                        REPEATING <= 1'b0;
                        if (TICK_EN && (rcnt_r == DELAY_LIM)) begin
                            STEP      <= 1'b1;
                            state_r   <= ST_REPEAT;
                            rcnt_r    <= '0;
                            REPEATING <= 1'b1;
                        end else if (TICK_EN) begin
                            rcnt_r <= rcnt_r + CNT_ONE;
                        end else begin
                            rcnt_r <= rcnt_r;
                        end
                    end
                    ST_REPEAT: begin
                        REPEATING <= 1'b1;
                        if (TICK_EN && (rcnt_r == RATE_LIM)) begin
                            STEP   <= 1'b1;
                            rcnt_r <= '0;
                        end else if (TICK_EN) begin
                            rcnt_r <= rcnt_r + CNT_ONE;
                        end else begin
                            rcnt_r <= rcnt_r;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        rcnt_r    <= '0;
                        REPEATING <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_repeat.sv
// Self-checking bench for button_repeat (DB=4, DELAY=8, RATE=3, active-low).
// A monitor logs every output pulse as cycle*4+kind (0=DOWN, 1=UP, 2=STEP);
// each test pushes the pulses it expects while driving the pin, then
// compares its expected queue against the logged pulses.
module tb_button_repeat;

    logic CLK = 1'b0;
    logic RST;
    logic TICK_EN;
    logic PB;
    logic PB_STATE;
    logic PB_DOWN;
    logic PB_UP;
    logic STEP;
    logic REPEATING;

    int cyc = 0;
    int obs_ev[$];
    int checks = 0;
    int errors = 0;

    button_repeat #(
        .ACTIVE_LOW  (1'b1),
        .CNT_W       (16),
        .DB_TICKS    (4),
        .DELAY_TICKS (8),
        .RATE_TICKS  (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .TICK_EN   (TICK_EN),
        .PB        (PB),
        .PB_STATE  (PB_STATE),
        .PB_DOWN   (PB_DOWN),
        .PB_UP     (PB_UP),
        .STEP      (STEP),
        .REPEATING (REPEATING)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (PB_DOWN) obs_ev.push_back(cyc * 4 + 0);
        if (PB_UP)   obs_ev.push_back(cyc * 4 + 1);
        if (STEP)    obs_ev.push_back(cyc * 4 + 2);
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        PB = 1'b1;
        TICK_EN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        PB = 1'b1;
        TICK_EN = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({PB_STATE, PB_DOWN, PB_UP, STEP, REPEATING} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {PB_STATE, PB_DOWN, PB_UP, STEP, REPEATING});
        end
        base = obs_ev.size();
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if (PB_STATE !== 1'b0 || obs_ev.size() != base) begin
            errors++;
            $display("FAIL reset_idle: got state=%b events=%0d, expected state=0 events=0",
                     PB_STATE, obs_ev.size() - base);
        end
    endtask

    task automatic test_clean_press();
        int expq[$];
        int t0, base;
        do_reset();
        base = obs_ev.size();
        @(negedge CLK);
        t0 = cyc;
        PB = 1'b0;
        expq.push_back((t0 + 6) * 4 + 0);
        expq.push_back((t0 + 6) * 4 + 2);
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (i == 5) begin
                checks++;
                if (PB_STATE !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_early_state: got %b, expected 0", PB_STATE);
                end
            end
            if (i == 6) begin
                checks++;
                if ({PB_STATE, REPEATING} !== 2'b10) begin
                    errors++;
                    $display("FAIL clean_state: got state,rep=%b, expected 10", {PB_STATE, REPEATING});
                end
            end
            if (i == 7) begin
                PB = 1'b1;
                expq.push_back((t0 + 13) * 4 + 1);
            end
        end
        begin
            int got[$];
            for (int k = base; k < obs_ev.size(); k++) got.push_back(obs_ev[k]);
            got.sort();
            expq.sort();
            checks++;
            if (got.size() != expq.size()) begin
                errors++;
                $display("FAIL clean_count: got %0d events, expected %0d", got.size(), expq.size());
            end else begin
                for (int k = 0; k < got.size(); k++) begin
                    checks++;
                    if (got[k] !== expq[k]) begin
                        errors++;
                        $display("FAIL clean_event%0d: got cyc=%0d kind=%0d, expected cyc=%0d kind=%0d",
                                 k, got[k] / 4, got[k] % 4, expq[k] / 4, expq[k] % 4);
                    end
                end
            end
        end
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = obs_ev.size();
        @(negedge CLK);
        for (int r = 0; r < 5; r++) begin
            PB = 1'b0;
            repeat (3) @(negedge CLK);
            PB = 1'b1;
            repeat (2) @(negedge CLK);
        end
        repeat (12) @(negedge CLK);
        checks++;
        if (PB_STATE !== 1'b0) begin
            errors++;
            $display("FAIL bounce_state: got %b, expected 0", PB_STATE);
        end
        checks++;
        if (obs_ev.size() != base) begin
            errors++;
            $display("FAIL bounce_count: got %0d events, expected 0", obs_ev.size() - base);
        end
    endtask

    task automatic test_hold_repeat();
        int expq[$];
        int t0, tp, tu, base;
        do_reset();
        base = obs_ev.size();
        @(negedge CLK);
        t0 = cyc;
        PB = 1'b0;
        tp = t0 + 6;
        tu = t0 + 25 + 6;
        expq.push_back(tp * 4 + 0);
        expq.push_back(tp * 4 + 2);
        for (int s = tp + 8; s < tu; s += 3) expq.push_back(s * 4 + 2);
        for (int i = 1; i <= 36; i++) begin
            @(negedge CLK);
            if (i == 25) begin
                PB = 1'b1;
                expq.push_back(tu * 4 + 1);
            end
            if (i == 13) begin
                checks++;
                if (REPEATING !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_rep_before: got %b, expected 0", REPEATING);
                end
            end
            if (i == 14 || i == 30) begin
                checks++;
                if (REPEATING !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_rep_on@%0d: got %b, expected 1", i, REPEATING);
                end
            end
        end
        checks++;
        if ({PB_STATE, REPEATING} !== 2'b00) begin
            errors++;
            $display("FAIL hold_after_release: got state,rep=%b, expected 00", {PB_STATE, REPEATING});
        end
        begin
            int got[$];
            for (int k = base; k < obs_ev.size(); k++) got.push_back(obs_ev[k]);
            got.sort();
            expq.sort();
            checks++;
            if (got.size() != expq.size()) begin
                errors++;
                $display("FAIL hold_count: got %0d events, expected %0d", got.size(), expq.size());
            end else begin
                for (int k = 0; k < got.size(); k++) begin
                    checks++;
                    if (got[k] !== expq[k]) begin
                        errors++;
                        $display("FAIL hold_event%0d: got cyc=%0d kind=%0d, expected cyc=%0d kind=%0d",
                                 k, got[k] / 4, got[k] % 4, expq[k] / 4, expq[k] % 4);
                    end
                end
            end
        end
    endtask

    task automatic test_release_on_expiry();
        int expq[$];
        int t0, base;
        do_reset();
        base = obs_ev.size();
        @(negedge CLK);
        t0 = cyc;
        PB = 1'b0;
        expq.push_back((t0 + 6) * 4 + 0);
        expq.push_back((t0 + 6) * 4 + 2);
        for (int i = 1; i <= 22; i++) begin
            @(negedge CLK);
            if (i == 8) begin
                PB = 1'b1;
                expq.push_back((t0 + 14) * 4 + 1);
            end
            if (i == 14 || i == 15) begin
                checks++;
                if ({STEP, REPEATING} !== 2'b00) begin
                    errors++;
                    $display("FAIL expiry_step_rep@%0d: got %b, expected 00", i, {STEP, REPEATING});
                end
            end
        end
        begin
            int got[$];
            for (int k = base; k < obs_ev.size(); k++) got.push_back(obs_ev[k]);
            got.sort();
            expq.sort();
            checks++;
            if (got.size() != expq.size()) begin
                errors++;
                $display("FAIL expiry_count: got %0d events, expected %0d", got.size(), expq.size());
            end else begin
                for (int k = 0; k < got.size(); k++) begin
                    checks++;
                    if (got[k] !== expq[k]) begin
                        errors++;
                        $display("FAIL expiry_event%0d: got cyc=%0d kind=%0d, expected cyc=%0d kind=%0d",
                                 k, got[k] / 4, got[k] % 4, expq[k] / 4, expq[k] % 4);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_in_repeat();
        int expq[$];
        int t0, base;
        do_reset();
        base = obs_ev.size();
        @(negedge CLK);
        t0 = cyc;
        PB = 1'b0;
        expq.push_back((t0 + 6) * 4 + 0);
        expq.push_back((t0 + 6) * 4 + 2);
        expq.push_back((t0 + 14) * 4 + 2);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (i == 15) begin
                checks++;
                if (REPEATING !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_rep_pre: got %b, expected 1", REPEATING);
                end
                RST = 1'b1;
            end
            if (i == 16) begin
                RST = 1'b0;
                checks++;
                if ({PB_STATE, PB_DOWN, PB_UP, STEP, REPEATING} !== 5'b00000) begin
                    errors++;
                    $display("FAIL rst_outputs: got %b, expected 00000",
                             {PB_STATE, PB_DOWN, PB_UP, STEP, REPEATING});
                end
                expq.push_back((t0 + 22) * 4 + 0);
                expq.push_back((t0 + 22) * 4 + 2);
            end
            if (i == 21 || i == 22) begin
                checks++;
                if (PB_STATE !== (i == 22)) begin
                    errors++;
                    $display("FAIL rst_repress@%0d: got %b, expected %b", i, PB_STATE, (i == 22));
                end
            end
            if (i == 23) begin
                PB = 1'b1;
                expq.push_back((t0 + 29) * 4 + 1);
            end
        end
        begin
            int got[$];
            for (int k = base; k < obs_ev.size(); k++) got.push_back(obs_ev[k]);
            got.sort();
            expq.sort();
            checks++;
            if (got.size() != expq.size()) begin
                errors++;
                $display("FAIL rst_count: got %0d events, expected %0d", got.size(), expq.size());
            end else begin
                for (int k = 0; k < got.size(); k++) begin
                    checks++;
                    if (got[k] !== expq[k]) begin
                        errors++;
                        $display("FAIL rst_event%0d: got cyc=%0d kind=%0d, expected cyc=%0d kind=%0d",
                                 k, got[k] / 4, got[k] % 4, expq[k] / 4, expq[k] % 4);
                    end
                end
            end
        end
    endtask

    task automatic test_sparse_tick();
        int t0, base;
        int n_dn, n_st, n_up, dn_cyc, st_cyc;
        do_reset();
        base = obs_ev.size();
        @(negedge CLK);
        t0 = cyc;
        PB = 1'b0;
        for (int i = 0; i < 60; i++) begin
            TICK_EN = (i <= 20) && (i % 4 == 0);
            if (i == 30) PB = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if ({PB_STATE, REPEATING} !== 2'b10) begin
            errors++;
            $display("FAIL sparse_frozen: got state,rep=%b, expected 10", {PB_STATE, REPEATING});
        end
        TICK_EN = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if (PB_STATE !== 1'b0) begin
            errors++;
            $display("FAIL sparse_release: got %b, expected 0", PB_STATE);
        end
        n_dn = 0;
        n_st = 0;
        n_up = 0;
        dn_cyc = -1;
        st_cyc = -1;
        for (int k = base; k < obs_ev.size(); k++) begin
            case (obs_ev[k] % 4)
                0: begin n_dn++; dn_cyc = obs_ev[k] / 4; end
                1: n_up++;
                default: begin n_st++; st_cyc = obs_ev[k] / 4; end
            endcase
        end
        checks++;
        if (n_dn != 1 || dn_cyc < t0 + 2 + 13 || dn_cyc > t0 + 2 + 19) begin
            errors++;
            $display("FAIL sparse_down: got n=%0d at +%0d, expected n=1 within +15..+21",
                     n_dn, dn_cyc - t0);
        end
        checks++;
        if (n_st != 1 || st_cyc != dn_cyc) begin
            errors++;
            $display("FAIL sparse_step: got n=%0d at cyc %0d, expected n=1 at cyc %0d",
                     n_st, st_cyc, dn_cyc);
        end
        checks++;
        if (n_up != 1) begin
            errors++;
            $display("FAIL sparse_up: got %0d, expected 1", n_up);
        end
    endtask

    initial begin
        RST = 1'b1;
        PB = 1'b1;
        TICK_EN = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_release_on_expiry();
        test_reset_in_repeat();
        test_sparse_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
